// File: rtl/seven_segment_scan_controller.sv
// Scan controller for an N-digit common-anode 7-segment display.
// Holds a double-buffered {hex value, dot mask, enable mask}. Each digit gets
// a fixed slot that opens with a short all-dark gap to suppress ghosting.
// Every pin is registered from the current scan state, so the pins trail the
// state by one clock.
module seven_segment_scan_controller #(
  parameter int DIGITS           = 8,
  parameter int CYCLES_PER_DIGIT = 100000,
  parameter int BLANK_CYCLES     = 1000
) (
  input  logic                  clk100mhz,
  input  logic                  cpu_resetn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     enable,
  output logic                  ca,
  output logic                  cb,
  output logic                  cc,
  output logic                  cd,
  output logic                  ce,
  output logic                  cf,
  output logic                  cg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = $clog2(CYCLES_PER_DIGIT);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] num;
    logic [DIGITS-1:0]      dots;
    logic [DIGITS-1:0]      en;
  } disp_buf_t;

  // Lit-segment pattern {g,f,e,d,c,b,a} for a hex nibble
  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  disp_buf_t     pend_q, pend_d;
  disp_buf_t     act_q, act_d;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fs_q;

  logic slot_end, wrap, in_blank, drive;
  logic [3:0] cur_nib;

  // Slot/digit sequencing and buffer handoff; the frame wrap copies the
  // pending buffer as it stood before this edge, so a coincident load waits
  // one more frame.
  always_comb begin
    slot_end = (cnt_q == CW'(CYCLES_PER_DIGIT - 1));
    wrap     = slot_end && (idx_q == IW'(DIGITS - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;
    pend_d = pend_q;
    if (load) begin
      pend_d.num  = number;
      pend_d.dots = dots;
      pend_d.en   = enable;
    end
    act_d = wrap ? pend_q : act_q;
  end

  // Pin values for the current state: dark during the blank gap or for a
  // disabled digit, otherwise one anode low with its decoded cathodes.
  always_comb begin
    in_blank = (32'(cnt_q) < BLANK_CYCLES);
    cur_nib  = act_q.num[idx_q];
    drive    = !in_blank && act_q.en[idx_q];
    an_d     = '1;
    seg_d    = '1;
    dp_d     = 1'b1;
    if (drive) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = ~seg_pattern(cur_nib);
      dp_d  = ~act_q.dots[idx_q];
    end
  end

  // Scan state and buffers; reset clears everything and restarts at digit 0
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  // Registered pins; reset forces them dark immediately
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      seg_q <= '1;
      dp_q  <= 1'b1;
      an_q  <= '1;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fs_q  <= wrap;
    end
  end

  assign {cg, cf, ce, cd, cc, cb, ca} = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the 7-segment scan controller (8 digits, 8-clock slots,
// 2-clock blank gap). Frames are checked cycle by cycle against a small model;
// a vector table adds hand-computed probe values for one digit per frame.
module tb_seven_segment_scan_controller;

  localparam int D   = 8;
  localparam int CPD = 8;
  localparam int BLK = 2;
  localparam int FRM = D * CPD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [31:0] number = '0;
  logic [7:0]  dots = '0;
  logic [7:0]  enable = '0;
  logic ca, cb, cc, cd, ce, cf, cg, dp, frame_start;
  logic [7:0] an;
  logic [6:0] seg;

  int compared = 0;
  int mismatched = 0;

  assign seg = {cg, cf, ce, cd, cc, cb, ca};

  always #5 clk = ~clk;

  seven_segment_scan_controller #(
    .DIGITS(D), .CYCLES_PER_DIGIT(CPD), .BLANK_CYCLES(BLK)
  ) dut (
    .clk100mhz(clk), .cpu_resetn(rst_n), .load(load),
    .number(number), .dots(dots), .enable(enable),
    .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg),
    .dp(dp), .an(an), .frame_start(frame_start)
  );

  typedef struct {
    logic [31:0] num;
    logic [7:0]  dots;
    logic [7:0]  en;
  } frm_t;

  typedef struct {
    frm_t       d;
    int         probe;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;

  logic [6:0] pat [16];
  logic [7:0] cap_an  [D];
  logic [6:0] cap_seg [D];
  logic       cap_dp  [D];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one frame starting from the negedge of a frame_start cycle (cycle 0).
  // Cycle k shows the state of cycle k-1. A load can be driven at cycle ld_k
  // so it is captured on the edge that ends that cycle (63 = the wrap edge).
  task automatic frame_check(input frm_t e, input int ld_k, input frm_t ld);
    for (int k = 1; k <= FRM; k++) begin
      int idx, c;
      logic drv;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] nib;
      @(negedge clk);
      idx   = (k - 1) / CPD;
      c     = (k - 1) % CPD;
      nib   = e.num[4*idx +: 4];
      drv   = (c >= BLK) && e.en[idx];
      e_an  = drv ? ~(8'd1 << idx) : 8'hFF;
      e_seg = drv ? ~pat[nib] : 7'h7F;
      e_dp  = drv ? ~e.dots[idx] : 1'b1;
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_start", 32'(frame_start), 32'(k == FRM));
      if (c == BLK) begin
        cap_an[idx]  = an;
        cap_seg[idx] = seg;
        cap_dp[idx]  = dp;
      end
      if (k == ld_k) begin
        load = 1'b1; number = ld.num; dots = ld.dots; enable = ld.en;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  vec_t vecs [6];
  frm_t zero_f, prev, wr_f;
  bit   found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    zero_f = '{num: 32'h0, dots: 8'h00, en: 8'h00};
    wr_f   = '{num: 32'h01234567, dots: 8'hFF, en: 8'hFF};
    //               number         dots   en     probe an     seg    dp
    vecs[0] = '{'{32'h76543210, 8'h00, 8'hFF}, 0, 8'hFE, 7'h40, 1'b1};
    vecs[1] = '{'{32'h76543210, 8'h00, 8'hFF}, 3, 8'hF7, 7'h30, 1'b1};
    vecs[2] = '{'{32'h76543210, 8'h04, 8'h05}, 2, 8'hFB, 7'h24, 1'b0};
    vecs[3] = '{'{32'h76543210, 8'h04, 8'h05}, 1, 8'hFF, 7'h7F, 1'b1};
    vecs[4] = '{'{32'hFFFFFFFF, 8'h00, 8'hFF}, 5, 8'hDF, 7'h0E, 1'b1};
    vecs[5] = '{'{32'h89ABCDEF, 8'h80, 8'h80}, 7, 8'h7F, 7'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);

    // Release: dark, first frame_start after exactly one frame of edges
    rst_n = 1'b1;
    found = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      chk("dark_after_rst", 32'(an), 32'hFF);
      if (frame_start) begin
        chk("first_fs_delay", 32'(n), 32'(FRM));
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      compared++; mismatched++;
      $display("FAIL first_fs_timeout: no frame_start within 100 clocks");
    end

    // Table: each vector is loaded mid-frame (frame still shows old data),
    // then shown in full on the next frame and probed at one digit
    prev = zero_f;
    foreach (vecs[i]) begin
      frame_check(prev, 20, vecs[i].d);
      frame_check(vecs[i].d, 0, zero_f);
      chk($sformatf("probe%0d_an", i),  32'(cap_an[vecs[i].probe]),  32'(vecs[i].exp_an));
      chk($sformatf("probe%0d_seg", i), 32'(cap_seg[vecs[i].probe]), 32'(vecs[i].exp_seg));
      chk($sformatf("probe%0d_dp", i),  32'(cap_dp[vecs[i].probe]),  32'(vecs[i].exp_dp));
      prev = vecs[i].d;
    end

    // Load on the wrap edge: active takes old pending, new data one frame later
    frame_check(prev, 63, wr_f);
    frame_check(prev, 0, zero_f);
    frame_check(wr_f, 0, zero_f);

    // Reset during a DRIVE cycle: pins go dark without waiting for a clock
    repeat (3) @(negedge clk);
    chk("pre_rst_drive_an", 32'(an), 32'hFE);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'hFF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Buffers were cleared: dark until a load plus a frame wrap
    frame_check(zero_f, 20, vecs[0].d);
    frame_check(vecs[0].d, 0, zero_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
